alu_seq_muldiv: RTL

- Parametrised, handshaked successor of the single-cycle execute ALU.
- Single-cycle ops: result registered with latency 1.
- Multiply: fixed MUL_LATENCY cycles. Divide: iterative, WIDTH cycles.
- Both give full 2×WIDTH products and quotient/remainder.
- Sits in EX; drives the HI/LO write path and the EX/MEM result register. Only one operation in flight.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_div_iter.sv | 80 ++++++++
 rtl/alu_seq_muldiv.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and immediate-extension rule for the sequential mul/div ALU.
// The divider is built only when ALU_SEQ_DIV_EN is defined.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_NOR  = 4'b0011;
   localparam logic [3:0] ALU_MULU = 4'b0100;
   localparam logic [3:0] ALU_DEF  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b1001;
   localparam logic [3:0] ALU_DIV  = 4'b1010;
   localparam logic [3:0] ALU_DIVU = 4'b1011;
   localparam logic [3:0] ALU_XOR  = 4'b1100;
   localparam logic [3:0] ALU_SLL  = 4'b1101;
   localparam logic [3:0] ALU_SRL  = 4'b1110;
   localparam logic [3:0] ALU_MUL  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } alu_state_t;

   // Logical ops take a zero-extended immediate; everything else sign-extends.
   localparam logic [3:0] IMM_ZEXT_OPS [4] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR};

   function automatic logic imm_zero_ext(input logic [3:0] op);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (op == IMM_ZEXT_OPS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes, signs fixed on output.
// Instantiated by alu_seq_muldiv only when ALU_SEQ_DIV_EN is defined.
module alu_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] rem, quo, dvs, dvd;
   logic [WIDTH-1:0] mag_a, mag_b, rem_in, quo_in, dvs_in, rem_s, quo_s;
   logic [WIDTH+1:0] diff;
   logic [CNT_W-1:0] cnt;
   logic             active, neg_q, neg_r, by_zero;

   assign mag_a = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
   assign mag_b = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The start cycle already performs the first iteration, so WIDTH steps end WIDTH-1 edges later.
   assign rem_in = start ? '0    : rem;
   assign quo_in = start ? mag_a : quo;
   assign dvs_in = start ? mag_b : dvs;

   always_comb begin
      diff = {1'b0, rem_in, quo_in[WIDTH-1]} - {2'b00, dvs_in};
      if (diff[WIDTH+1]) begin
         rem_s = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
         quo_s = {quo_in[WIDTH-2:0], 1'b0};
      end else begin
         rem_s = diff[WIDTH-1:0];
         quo_s = {quo_in[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         dvd     <= '0;
         cnt     <= '0;
         active  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         by_zero <= 1'b0;
      end else if (start) begin
         rem     <= rem_s;
         quo     <= quo_s;
         dvs     <= mag_b;
         dvd     <= dividend;
         cnt     <= CNT_W'(WIDTH - 1);
         active  <= 1'b1;
         neg_q   <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_r   <= sgn && dividend[WIDTH-1];
         by_zero <= (divisor == '0);
      end else if (active) begin
         if (cnt != '0) begin
            rem <= rem_s;
            quo <= quo_s;
            cnt <= cnt - 1'b1;
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign done      = active && (cnt == '0);
   assign quotient  = by_zero ? '1  : (neg_q ? -quo : quo);
   assign remainder = by_zero ? dvd : (neg_r ? -rem : rem);

endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked EX-stage ALU: single-cycle ops, fixed-latency multiply, optional iterative divide.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise div opcodes behave like the default op.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 3,
   parameter int SHAMT_W     = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [WIDTH-1:0]   data_a,
   input  logic [WIDTH-1:0]   data_b,
   input  logic [15:0]        imme,
   input  logic               ALUSrc,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   alu_result,
   output logic [WIDTH-1:0]   alu_result_hi,
   output logic               busy
);

   localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   alu_state_t         state, state_nxt;
   logic               accept, is_mul, is_div, load, use_live, m_sgn, sgn_q;
   logic [WIDTH-1:0]   imm_ext, op_b, sc_res, res_nxt, hi_nxt;
   logic [WIDTH-1:0]   a_q, b_q, m_a, m_b;
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   cnt;

   assign accept  = in_valid && in_ready;
   assign is_mul  = (alu_control == ALU_MUL) || (alu_control == ALU_MULU);
   assign imm_ext = imm_zero_ext(alu_control) ? {{(WIDTH-16){1'b0}}, imme}
                                              : {{(WIDTH-16){imme[15]}}, imme};
   assign op_b    = ALUSrc ? imm_ext : data_b;

   always_comb begin
      sc_res = '0;
      case (alu_control)
         ALU_ADD:  sc_res = data_a + op_b;
         ALU_SUB:  sc_res = data_a - op_b;
         ALU_AND:  sc_res = data_a & op_b;
         ALU_OR:   sc_res = data_a | op_b;
         ALU_XOR:  sc_res = data_a ^ op_b;
         ALU_NOR:  sc_res = ~(data_a | op_b);
         ALU_SLTU: sc_res = WIDTH'(data_a < op_b);
         ALU_SLT:  sc_res = WIDTH'($signed(data_a) < $signed(op_b));
         ALU_SLL:  sc_res = op_b << shamt;
         ALU_SRL:  sc_res = op_b >> shamt;
         ALU_SRA:  sc_res = $signed(op_b) >>> shamt;
         default:  sc_res = '0;
      endcase
   end

   // Live operands feed the multiplier only for the latency-1 case; otherwise the captured copies do.
   assign use_live = (state != MUL);
   assign m_a      = use_live ? data_a : a_q;
   assign m_b      = use_live ? op_b   : b_q;
   assign m_sgn    = use_live ? (alu_control == ALU_MUL) : sgn_q;
   assign prod     = {{WIDTH{m_sgn & m_a[WIDTH-1]}}, m_a} * {{WIDTH{m_sgn & m_b[WIDTH-1]}}, m_b};

`ifdef ALU_SEQ_DIV_EN
   logic             div_start, div_done;
   logic [WIDTH-1:0] div_q, div_r;

   assign is_div = (alu_control == ALU_DIV) || (alu_control == ALU_DIVU);

   alu_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .sgn       (alu_control == ALU_DIV),
      .dividend  (data_a),
      .divisor   (op_b),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );
`else
   assign is_div = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      res_nxt   = '0;
      hi_nxt    = '0;
`ifdef ALU_SEQ_DIV_EN
      div_start = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               if (is_mul) begin
                  if (MUL_LATENCY == 1) begin
                     state_nxt = DONE;
                     load      = 1'b1;
                     res_nxt   = prod[WIDTH-1:0];
                     hi_nxt    = prod[2*WIDTH-1:WIDTH];
                  end else begin
                     state_nxt = MUL;
                  end
               end else if (is_div) begin
                  state_nxt = DIV;
`ifdef ALU_SEQ_DIV_EN
                  div_start = 1'b1;
`endif
               end else begin
                  state_nxt = DONE;
                  load      = 1'b1;
                  res_nxt   = sc_res;
               end
            end else if (state == DONE && out_ready) begin
               state_nxt = IDLE;
            end
         end
         MUL: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
               load      = 1'b1;
               res_nxt   = prod[WIDTH-1:0];
               hi_nxt    = prod[2*WIDTH-1:WIDTH];
            end
         end
         DIV: begin
`ifdef ALU_SEQ_DIV_EN
            if (div_done) begin
               state_nxt = DONE;
               load      = 1'b1;
               res_nxt   = div_q;
               hi_nxt    = div_r;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result    <= '0;
         alu_result_hi <= '0;
         a_q           <= '0;
         b_q           <= '0;
         sgn_q         <= 1'b0;
         cnt           <= '0;
      end else begin
         if (load) begin
            alu_result    <= res_nxt;
            alu_result_hi <= hi_nxt;
         end
         if (accept && is_mul) begin
            a_q   <= data_a;
            b_q   <= op_b;
            sgn_q <= (alu_control == ALU_MUL);
            cnt   <= CNT_W'(MUL_LATENCY - 1);
         end else if (state == MUL) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign out_valid = (state == DONE);
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign busy      = (state == MUL) || (state == DIV);

endmodule
